// File: rtl/mioc_ws_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mioc_ws_if                                                    |
// | Brief    : MEM-stage request, RAM bus and IO bus signal bundle for       |
// |            mioc_ws. slave = steering block view, master = environment.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mioc_ws_if #(
  parameter int DATA_W = 32,
  parameter int IO_CH  = 4
) ();
  // pipeline side
  logic                    req_i;
  logic                    we_i;
  logic [1:0]              size_i;
  logic                    sign_i;
  logic [DATA_W-1:0]       addr_i;
  logic [DATA_W-1:0]       wdata_i;
  logic [DATA_W-1:0]       rdata_o;
  logic                    done_o;
  logic                    err_o;
  logic                    stall_o;
  // data RAM
  logic                    mem_ce;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_addr;
  logic [3:0]              mem_sel;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  // IO channels
  logic [IO_CH-1:0]        io_ce;
  logic                    io_we;
  logic [DATA_W-1:0]       io_addr;
  logic [DATA_W-1:0]       io_wdata;
  logic [IO_CH*DATA_W-1:0] io_rdata;
  logic [IO_CH-1:0]        io_ack;

  modport slave (
    input  req_i, we_i, size_i, sign_i, addr_i, wdata_i,
    output rdata_o, done_o, err_o, stall_o,
    output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_rdata,
    output io_ce, io_we, io_addr, io_wdata,
    input  io_rdata, io_ack
  );

  modport master (
    output req_i, we_i, size_i, sign_i, addr_i, wdata_i,
    input  rdata_o, done_o, err_o, stall_o,
    input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_rdata,
    input  io_ce, io_we, io_addr, io_wdata,
    output io_rdata, io_ack
  );
endinterface
`default_nettype wire

// File: rtl/mioc_ws.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mioc_ws                                                       |
// | Brief    : MEM-stage load/store steering to data RAM or IO channels with |
// |            big-endian byte lanes, RAM wait states and IO ack/timeout.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mioc_ws #(
  parameter int         DATA_W     = 32,
  parameter int         IO_CH      = 4,
  parameter logic [3:0] IO_REGION  = 4'hB,
  parameter int         MEM_WAIT   = 1,
  parameter int         IO_TIMEOUT = 15
) (
  input wire         clk,
  input wire         rst,
  mioc_ws_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] c_io_ch    = 5'(IO_CH);
  localparam logic [7:0] c_mem_last = 8'(MEM_WAIT);
  localparam logic [7:0] c_io_last  = 8'(IO_TIMEOUT - 1);

  logic [1:0]        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_sel;
  logic [3:0]        r_ch;
  logic [7:0]        r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_is_io;
  logic              w_bad;
  logic [3:0]        w_sel;
  logic [DATA_W-1:0] w_rep;
  logic [IO_CH-1:0]  w_ch_oh;
  logic              w_ack;
  logic [DATA_W-1:0] w_io_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_rd;

  // Request decode: region, error conditions, byte lanes, replicated store data
  always_comb begin
    w_is_io = (bus.addr_i[31:28] == IO_REGION);
    w_bad   = (bus.size_i == 2'b11)
            | ((bus.size_i == 2'b01) & bus.addr_i[0])
            | ((bus.size_i == 2'b10) & (bus.addr_i[1:0] != 2'b00))
            | (w_is_io & ({1'b0, bus.addr_i[11:8]} >= c_io_ch));
    w_sel = 4'b0000;
    w_rep = bus.wdata_i;
    case (bus.size_i)
      2'b00: begin
        w_rep = {4{bus.wdata_i[7:0]}};
        case (bus.addr_i[1:0])
          2'b00:   w_sel = 4'b1000;
          2'b01:   w_sel = 4'b0100;
          2'b10:   w_sel = 4'b0010;
          default: w_sel = 4'b0001;
        endcase
      end
      2'b01: begin
        w_rep = {2{bus.wdata_i[15:0]}};
        w_sel = bus.addr_i[1] ? 4'b0011 : 4'b1100;
      end
      2'b10:   w_sel = 4'b1111;
      default: w_sel = 4'b0000;
    endcase
  end

  // Selected IO channel: one-hot enable, its ack and its read word
  always_comb begin
    w_ch_oh   = '0;
    w_io_word = '0;
    for (int k = 0; k < IO_CH; k++) begin
      w_ch_oh[k] = (r_ch == 4'(k));
      w_io_word  = w_io_word | (bus.io_rdata[k*DATA_W +: DATA_W] & {DATA_W{w_ch_oh[k]}});
    end
    w_ack = |(bus.io_ack & w_ch_oh);
  end

  // Transaction FSM: accept in IDLE, wait out RAM / IO, one DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= 4'b0000;
      r_ch    <= 4'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_i) begin
            r_we    <= bus.we_i;
            r_size  <= bus.size_i;
            r_sign  <= bus.sign_i;
            r_addr  <= bus.addr_i;
            r_wdata <= w_rep;
            r_sel   <= w_sel;
            r_ch    <= bus.addr_i[11:8];
            r_cnt   <= 8'd0;
            r_rdata <= '0;
            r_err   <= w_bad;
            if (w_bad)        r_state <= S_DONE;
            else if (w_is_io) r_state <= S_IO;
            else              r_state <= S_MEM;
          end
        end
        S_MEM: begin
          if (r_cnt == c_mem_last) begin
            r_rdata <= bus.mem_rdata;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_IO: begin
          // an ack in the timeout cycle still completes cleanly
          if (w_ack) begin
            r_rdata <= w_io_word;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == c_io_last) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Load result: lane extraction and sign/zero extension, zero outside DONE
  always_comb begin
    w_rd = '0;
    case (r_addr[1:0])
      2'b00:   w_byte = r_rdata[31:24];
      2'b01:   w_byte = r_rdata[23:16];
      2'b10:   w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_addr[1] ? r_rdata[15:0] : r_rdata[31:16];
    if ((r_state == S_DONE) && !r_we) begin
      case (r_size)
        2'b00:   w_rd = {{24{r_sign & w_byte[7]}}, w_byte};
        2'b01:   w_rd = {{16{r_sign & w_half[15]}}, w_half};
        2'b10:   w_rd = r_rdata;
        default: w_rd = '0;
      endcase
    end
  end

  assign bus.rdata_o   = w_rd;
  assign bus.done_o    = (r_state == S_DONE);
  assign bus.err_o     = (r_state == S_DONE) & r_err;
  assign bus.stall_o   = ((r_state == S_IDLE) & bus.req_i) | (r_state == S_MEM) | (r_state == S_IO);

  assign bus.mem_ce    = (r_state == S_MEM);
  assign bus.mem_we    = (r_state == S_MEM) & r_we;
  assign bus.mem_addr  = (r_state == S_MEM) ? {r_addr[DATA_W-1:2], 2'b00} : '0;
  assign bus.mem_sel   = (r_state == S_MEM) ? r_sel : 4'b0000;
  assign bus.mem_wdata = (r_state == S_MEM) ? r_wdata : '0;

  assign bus.io_ce     = (r_state == S_IO) ? w_ch_oh : '0;
  assign bus.io_we     = (r_state == S_IO) & r_we;
  assign bus.io_addr   = (r_state == S_IO) ? r_addr : '0;
  assign bus.io_wdata  = (r_state == S_IO) ? r_wdata : '0;

endmodule
`default_nettype wire

// File: doc/mioc_ws.md
Name: mioc_ws

Overview:
- Parametrised, sequential successor of the MEM-stage memory/IO steering block.
- Accepts one load/store request per transaction from the MEM stage and decodes it to data RAM or to one of IO_CH IO channels.
- Generates MIPS big-endian byte lanes for byte, half and word accesses.
- Inserts fixed RAM wait states and runs an ack/timeout handshake for IO.
- Stalls the pipeline until completion and reports errors.

Parameters:
- DATA_W, 32, data/address width; only 32 is supported.
- IO_CH, 4, number of IO channels; range 1..16.
- IO_REGION, 4'hB, value of addr[31:28] that selects IO space.
- MEM_WAIT, 1, extra RAM wait cycles; range 0..15.
- IO_TIMEOUT, 15, maximum cycles to wait for io_ack; range 1..255.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_i  in  1  access request, held by pipeline while stall_o=1
- we_i  in  1  1=store, 0=load
- size_i  in  2  00=byte, 01=half, 10=word; 11 is illegal
- sign_i  in  1  1=sign-extend load result
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- rdata_o  out  32  load result, valid while done_o=1
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error flag, valid with done_o
- stall_o  out  1  pipeline stall
- mem_ce  out  1  RAM chip enable
- mem_we  out  1  RAM write enable
- mem_addr  out  32  RAM address, word-aligned
- mem_sel  out  4  RAM byte lanes
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data
- io_ce  out  IO_CH  one-hot IO channel enable
- io_we  out  1  IO write enable
- io_addr  out  32  IO address
- io_wdata  out  32  IO write data
- io_rdata  in  IO_CH*32  flattened IO read data; channel k occupies bits [32k+31:32k]
- io_ack  in  IO_CH  per-channel acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including io_ce=0 and mem_sel=0.
  - Counters cleared.
  - Reset asserted mid-transaction aborts it immediately; no done_o is produced.
- FSM states: IDLE, MEM, IO, DONE.
- IDLE:
  - req_i is sampled only in this state.
  - On req_i=1, latch we/size/sign/addr/wdata.
  - Error check: size_i=11, or misaligned access (half with addr[0]=1; word with addr[1:0]!=0), or IO channel addr[11:8] >= IO_CH. Any of these -> DONE with err=1. No RAM/IO enable is ever asserted.
  - If addr[31:28]==IO_REGION -> IO, channel ch=addr[11:8].
  - Otherwise -> MEM, counter=0.
- stall_o = (state==IDLE & req_i) | state==MEM | state==IO. It is combinational and deasserts in the DONE cycle.
- Byte lanes (big-endian), with a = addr[1:0]:
  - byte: a=00 -> 1000, 01 -> 0100, 10 -> 0010, 11 -> 0001.
  - half: a=00 -> 1100, 10 -> 0011.
  - word: 1111.
- Store data is replicated across lanes: byte {4{b}}, half {2{h}}, word as-is.
- MEM state:
  - mem_ce=1, mem_we=we, mem_addr={addr[31:2],2'b00}, mem_sel=lanes, mem_wdata=replicated data.
  - All these are registered and held constant for MEM_WAIT+1 cycles.
  - On the final MEM cycle (counter==MEM_WAIT), capture mem_rdata, then go to DONE.
  - Load latency from the req_i accept edge to done_o = MEM_WAIT+2 cycles.
- IO state:
  - io_ce[ch]=1, io_we=we, io_addr=addr, io_wdata=replicated data.
  - Counter increments every cycle.
  - If io_ack[ch]=1 is sampled: capture io_rdata slice ch and go to DONE with err=0. Acks on other channels are ignored.
  - If counter reaches IO_TIMEOUT without ack: go to DONE with err=1 and rdata=0.
  - An ack that arrives in the same cycle as the timeout wins: err=0.
- DONE (exactly one cycle):
  - done_o=1 and err_o=err; all enables are 0.
  - rdata_o is the captured word, lane-extracted and sign/zero-extended per size/sign. Stores return rdata_o=0.
  - Next state is always IDLE, so back-to-back requests have a 1-cycle IDLE gap.
- Outside DONE, done_o=0, err_o=0 and rdata_o=0.

Test Plan:
- Reset: assert rst=0 during MEM state with MEM_WAIT=3 -> all outputs are 0 immediately; no done_o follows after release.
- Byte load: addr=0x0000_0102, size=00, sign=1, mem_rdata=0x1122_8344, MEM_WAIT=1 -> mem_sel=0010 held 2 cycles; done_o 3 cycles after accept; rdata_o=0xFFFF_FF83. Repeat with sign=0 -> rdata_o=0x0000_0083.
- Half store: addr=0x0000_0012, size=01, wdata=0x0000_ABCD -> mem_we=1, mem_sel=0011, mem_wdata=0xABCD_ABCD, mem_addr=0x10.
- IO load: addr=0xB000_0204 with io_ack[2] raised 4 cycles after io_ce=0100 -> rdata_o=io_rdata[95:64], err_o=0; stall_o drops in the done cycle.
- IO timeout: no ack, IO_TIMEOUT=15 -> done_o with err_o=1 and rdata_o=0 after 15 IO cycles; an ack on channel 1 while accessing channel 2 has no effect.
- Errors: word access at addr 0x3; size=11; addr 0xB000_0500 with IO_CH=4 -> each gives done_o=err_o=1 one cycle after accept, with mem_ce=0 and io_ce=0 throughout.
